fetch_decode: RTL and testbench

Instruction fetch and decode stage for the 9-bit core. It sits directly upstream of reg_file. It holds the PC, reads a synchronous-read instruction memory, and latches the 9-bit instruction. It then drives the register-file address fields (rs_addr, rt_addr, rd_addr) and the write enable, and handles relative branches, stalls and halt.

---
 rtl/fetch_decode.sv | 110 +++++++++++
 tb/tb_fetch_decode.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode.sv
// Instruction fetch and decode stage for the 9-bit core.
// Holds the PC, drives a synchronous-read instruction memory, latches the
// fetched instruction and presents the register-file address fields and
// write enable. Handles relative branches, stalls and a sticky halt.
module fetch_decode #(
  parameter int PC_W = 8,
  parameter int W    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stall,
  input  logic            branch_taken,
  output logic [PC_W-1:0] imem_addr,
  input  logic [W-1:0]    imem_data,
  output logic [PC_W-1:0] pc,
  output logic [W-1:0]    instr,
  output logic [2:0]      opcode,
  output logic [3:0]      rs_addr,
  output logic [1:0]      rt_addr,
  output logic [1:0]      rd_addr,
  output logic            write,
  output logic            instr_valid,
  output logic            halted
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    EXEC  = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [2:0]   OP_STORE   = 3'b110;
  localparam logic [2:0]   OP_BRANCH  = 3'b111;
  localparam logic [W-1:0] HALT_INSTR = W'(9'b111_000000);

  state_t state;
  logic   writes_op;

  // Next PC: signed relative branch when taken with a non-zero offset,
  // otherwise a plain increment. Both wrap modulo 2^PC_W.
  function automatic logic [PC_W-1:0] next_pc(
    input logic [PC_W-1:0] cur,
    input logic [W-1:0]    ins,
    input logic            taken
  );
    logic signed [5:0]      off;
    logic signed [PC_W-1:0] off_ext;
    off     = signed'(ins[5:0]);
    off_ext = {{(PC_W-6){off[5]}}, off};
    if ((ins[W-1 -: 3] == OP_BRANCH) && (off != 6'sd0) && taken)
      return cur + PC_W'(off_ext);
    return cur + PC_W'(1);
  endfunction

  // Control FSM owning pc and the latched instruction; reset clears everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= '0;
      instr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= FETCH;
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          instr <= imem_data;
          state <= EXEC;
        end
        EXEC: begin
          if (!stall) begin
            if (instr == HALT_INSTR) begin
              state <= HALT;
            end else begin
              pc    <= next_pc(pc, instr, branch_taken);
              state <= FETCH;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign imem_addr   = pc;
  assign opcode      = instr[W-1 -: 3];
  assign rs_addr     = instr[5:2];
  assign rt_addr     = instr[1:0];
  assign rd_addr     = instr[1:0];
  assign instr_valid = (state == EXEC);
  assign halted      = (state == HALT);

  // Register-file write fires only on the final (unstalled) EXEC cycle.
  always_comb begin
    writes_op = (opcode != OP_STORE) && (opcode != OP_BRANCH);
    write     = (state == EXEC) && !stall && writes_op;
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Testbench for fetch_decode: synchronous-read memory model, a scoreboard of
// expected completed instructions, and one task per scenario.
module tb_fetch_decode;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stall;
  logic       branch_taken;
  logic [7:0] imem_addr;
  logic [8:0] imem_data;
  logic [7:0] pc;
  logic [8:0] instr;
  logic [2:0] opcode;
  logic [3:0] rs_addr;
  logic [1:0] rt_addr;
  logic [1:0] rd_addr;
  logic       write;
  logic       instr_valid;
  logic       halted;

  int total = 0;
  int bad   = 0;

  logic [8:0] imem [256];

  typedef struct {
    logic [7:0] pc;
    logic [8:0] instr;
    logic       wr;
  } rec_t;
  rec_t sb[$];

  localparam logic [8:0] HALT_I = 9'b111_000000;
  localparam logic [8:0] NOP_I  = 9'b000_0000_00;

  fetch_decode #(.PC_W(8), .W(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .branch_taken(branch_taken), .imem_addr(imem_addr), .imem_data(imem_data),
    .pc(pc), .instr(instr), .opcode(opcode), .rs_addr(rs_addr),
    .rt_addr(rt_addr), .rd_addr(rd_addr), .write(write),
    .instr_valid(instr_valid), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memory.
  always @(posedge clk) imem_data <= imem[imem_addr];

  // Scoreboard: every completed (unstalled) EXEC cycle must match the next record.
  always @(negedge clk) begin
    rec_t e;
    if (instr_valid === 1'b1 && stall === 1'b0) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: pc=%0d instr=%b write=%b, none expected", pc, instr, write);
      end else begin
        e = sb.pop_front();
        if (pc !== e.pc || instr !== e.instr || write !== e.wr) begin
          bad++;
          $display("FAIL sb_exec: got pc=%0d instr=%b write=%b, want pc=%0d instr=%b write=%b",
                   pc, instr, write, e.pc, e.instr, e.wr);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] a, input logic [8:0] i, input logic w);
    rec_t r;
    r.pc = a; r.instr = i; r.wr = w;
    sb.push_back(r);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) imem[i] = NOP_I;
    sb.delete();
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    tick(); tick();
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic start_pulse();
    #1 start = 1'b1;
    tick();
    #1 start = 1'b0;
  endtask

  task automatic wait_exec_at(input logic [7:0] a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (instr_valid === 1'b1 && pc === a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_halt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (halted === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear_mem();
    #1 rst_n = 1'b0; start = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    tick(); tick();
    total++;
    if ({pc, imem_addr, instr, opcode, rs_addr, rt_addr, rd_addr, write, instr_valid, halted} !== '0) begin
      bad++;
      $display("FAIL reset_held: pc=%0d addr=%0d instr=%b write=%b valid=%b halted=%b, want all 0",
               pc, imem_addr, instr, write, instr_valid, halted);
    end
    #1 rst_n = 1'b1; start = 1'b0;
    tick();
    total++;
    if ({pc, instr, write, instr_valid, halted} !== '0) begin
      bad++;
      $display("FAIL reset_after: pc=%0d instr=%b write=%b valid=%b halted=%b, want all 0",
               pc, instr, write, instr_valid, halted);
    end
    // With no start, the stage must stay idle.
    tick(); tick(); tick();
    total++;
    if (instr_valid !== 1'b0 || pc !== 8'd0) begin
      bad++;
      $display("FAIL idle_no_start: valid=%b pc=%0d, want 0 0", instr_valid, pc);
    end
  endtask

  task automatic test_basic_decode();
    bit ok;
    clear_mem();
    imem[0] = 9'b000_1000_01;
    imem[1] = NOP_I;
    imem[2] = HALT_I;
    do_reset();
    push(8'd0, 9'b000_1000_01, 1'b1);
    push(8'd1, NOP_I, 1'b1);
    push(8'd2, HALT_I, 1'b0);
    start_pulse();
    total++;
    if (instr_valid !== 1'b0) begin
      bad++; $display("FAIL lat_fetch: valid=%b want 0", instr_valid);
    end
    tick();
    total++;
    if (instr_valid !== 1'b0) begin
      bad++; $display("FAIL lat_load: valid=%b want 0", instr_valid);
    end
    tick();
    total++;
    if (instr_valid !== 1'b1 || opcode !== 3'd0 || rs_addr !== 4'd8 || rt_addr !== 2'd1 ||
        rd_addr !== 2'd1 || write !== 1'b1 || pc !== 8'd0) begin
      bad++;
      $display("FAIL decode_fields: valid=%b op=%0d rs=%0d rt=%0d rd=%0d write=%b pc=%0d, want 1 0 8 1 1 1 0",
               instr_valid, opcode, rs_addr, rt_addr, rd_addr, write, pc);
    end
    tick();
    total++;
    if (pc !== 8'd1 || instr_valid !== 1'b0 || write !== 1'b0) begin
      bad++;
      $display("FAIL next_fetch: pc=%0d valid=%b write=%b, want 1 0 0", pc, instr_valid, write);
    end
    wait_halt(ok);
    total++;
    if (!ok || pc !== 8'd2) begin
      bad++; $display("FAIL basic_halt: halted=%b pc=%0d, want 1 2", halted, pc);
    end
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL basic_sb_left: %0d records pending, want 0", sb.size());
    end
  endtask

  task automatic test_branch();
    bit ok;
    clear_mem();
    imem[5] = 9'b111_111110;
    imem[6] = HALT_I;
    do_reset();
    for (int i = 0; i < 5; i++) push(8'(i), NOP_I, 1'b1);
    push(8'd5, 9'b111_111110, 1'b0);
    push(8'd3, NOP_I, 1'b1);
    push(8'd4, NOP_I, 1'b1);
    push(8'd5, 9'b111_111110, 1'b0);
    push(8'd6, HALT_I, 1'b0);
    start_pulse();
    branch_taken = 1'b1;
    wait_exec_at(8'd5, ok);
    total++;
    if (!ok || write !== 1'b0) begin
      bad++; $display("FAIL br_taken_exec: reached=%b write=%b, want 1 0", ok, write);
    end
    tick();
    total++;
    if (pc !== 8'd3) begin
      bad++; $display("FAIL br_taken_pc: pc=%0d want 3", pc);
    end
    #1 branch_taken = 1'b0;
    wait_exec_at(8'd5, ok);
    total++;
    if (!ok || write !== 1'b0) begin
      bad++; $display("FAIL br_not_taken_exec: reached=%b write=%b, want 1 0", ok, write);
    end
    tick();
    total++;
    if (pc !== 8'd6) begin
      bad++; $display("FAIL br_not_taken_pc: pc=%0d want 6", pc);
    end
    wait_halt(ok);
    total++;
    if (!ok || sb.size() != 0) begin
      bad++; $display("FAIL br_end: halted=%b pending=%0d, want 1 0", halted, sb.size());
    end
  endtask

  task automatic test_stall_store();
    bit ok;
    clear_mem();
    imem[0] = 9'b000_0011_10;
    imem[1] = 9'b110_0000_00;
    imem[2] = HALT_I;
    do_reset();
    push(8'd0, 9'b000_0011_10, 1'b1);
    push(8'd1, 9'b110_0000_00, 1'b0);
    push(8'd2, HALT_I, 1'b0);
    start_pulse();
    stall = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (instr_valid !== 1'b1 || write !== 1'b0 || pc !== 8'd0 || instr !== 9'b000_0011_10 ||
          rs_addr !== 4'd3 || rd_addr !== 2'd2) begin
        bad++;
        $display("FAIL stall_hold%0d: valid=%b write=%b pc=%0d instr=%b, want 1 0 0 000001110",
                 c, instr_valid, write, pc, instr);
      end
    end
    @(posedge clk);
    #1 stall = 1'b0;
    tick();
    total++;
    if (instr_valid !== 1'b1 || write !== 1'b1 || pc !== 8'd0) begin
      bad++; $display("FAIL stall_release: valid=%b write=%b pc=%0d, want 1 1 0", instr_valid, write, pc);
    end
    tick();
    total++;
    if (write !== 1'b0 || pc !== 8'd1) begin
      bad++; $display("FAIL stall_after: write=%b pc=%0d, want 0 1", write, pc);
    end
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      total++;
      if (write !== 1'b0) begin
        bad++; $display("FAIL store_write: write=%b at pc=%0d, want 0", write, pc);
      end
      if (halted === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok || sb.size() != 0) begin
      bad++; $display("FAIL store_end: halted=%b pending=%0d, want 1 0", halted, sb.size());
    end
  endtask

  task automatic test_wrap();
    bit ok;
    clear_mem();
    imem[0]   = 9'b111_111111;
    imem[255] = 9'b001_0000_00;
    imem[1]   = NOP_I;
    imem[2]   = 9'b111_111101;
    imem[3]   = HALT_I;
    do_reset();
    push(8'd0,   9'b111_111111, 1'b0);
    push(8'd255, 9'b001_0000_00, 1'b1);
    push(8'd0,   9'b111_111111, 1'b0);
    push(8'd1,   NOP_I, 1'b1);
    push(8'd2,   9'b111_111101, 1'b0);
    push(8'd255, 9'b001_0000_00, 1'b1);
    push(8'd0,   9'b111_111111, 1'b0);
    push(8'd1,   NOP_I, 1'b1);
    push(8'd2,   9'b111_111101, 1'b0);
    push(8'd3,   HALT_I, 1'b0);
    start_pulse();
    branch_taken = 1'b1;
    wait_exec_at(8'd0, ok);
    tick();
    total++;
    if (!ok || pc !== 8'd255) begin
      bad++; $display("FAIL wrap_back: reached=%b pc=%0d, want 1 255", ok, pc);
    end
    #1 branch_taken = 1'b0;
    wait_exec_at(8'd255, ok);
    total++;
    if (!ok || write !== 1'b1) begin
      bad++; $display("FAIL wrap_exec255: reached=%b write=%b, want 1 1", ok, write);
    end
    tick();
    total++;
    if (pc !== 8'd0) begin
      bad++; $display("FAIL wrap_inc: pc=%0d want 0", pc);
    end
    wait_exec_at(8'd0, ok);
    tick();
    total++;
    if (!ok || pc !== 8'd1) begin
      bad++; $display("FAIL wrap_not_taken: reached=%b pc=%0d, want 1 1", ok, pc);
    end
    #1 branch_taken = 1'b1;
    wait_exec_at(8'd2, ok);
    tick();
    total++;
    if (!ok || pc !== 8'd255) begin
      bad++; $display("FAIL wrap_neg3: reached=%b pc=%0d, want 1 255", ok, pc);
    end
    #1 branch_taken = 1'b0;
    wait_halt(ok);
    total++;
    if (!ok || pc !== 8'd3 || sb.size() != 0) begin
      bad++; $display("FAIL wrap_end: halted=%b pc=%0d pending=%0d, want 1 3 0", halted, pc, sb.size());
    end
  endtask

  task automatic test_halt();
    bit ok;
    clear_mem();
    imem[7] = HALT_I;
    do_reset();
    for (int i = 0; i < 7; i++) push(8'(i), NOP_I, 1'b1);
    push(8'd7, HALT_I, 1'b0);
    start_pulse();
    branch_taken = 1'b1;
    wait_exec_at(8'd7, ok);
    total++;
    if (!ok || halted !== 1'b0) begin
      bad++; $display("FAIL halt_exec: reached=%b halted=%b, want 1 0", ok, halted);
    end
    tick();
    total++;
    if (halted !== 1'b1 || pc !== 8'd7 || instr_valid !== 1'b0 || write !== 1'b0) begin
      bad++;
      $display("FAIL halt_enter: halted=%b pc=%0d valid=%b write=%b, want 1 7 0 0",
               halted, pc, instr_valid, write);
    end
    for (int c = 0; c < 20; c++) begin
      if (c == 10) begin
        #1 start = 1'b1;
        tick();
        #1 start = 1'b0;
      end else begin
        tick();
      end
      total++;
      if (halted !== 1'b1 || pc !== 8'd7 || instr !== HALT_I || instr_valid !== 1'b0) begin
        bad++;
        $display("FAIL halt_frozen%0d: halted=%b pc=%0d instr=%b valid=%b, want 1 7 111000000 0",
                 c, halted, pc, instr, instr_valid);
      end
    end
    #1 rst_n = 1'b0;
    tick();
    total++;
    if (pc !== 8'd0 || halted !== 1'b0 || instr !== 9'd0 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL halt_reset: pc=%0d halted=%b instr=%b valid=%b, want 0 0 0 0",
               pc, halted, instr, instr_valid);
    end
    #1 rst_n = 1'b1; branch_taken = 1'b0;
    tick(); tick(); tick();
    total++;
    if (instr_valid !== 1'b0 || pc !== 8'd0 || halted !== 1'b0 || sb.size() != 0) begin
      bad++;
      $display("FAIL halt_idle: valid=%b pc=%0d halted=%b pending=%0d, want 0 0 0 0",
               instr_valid, pc, halted, sb.size());
    end
  endtask

  task automatic test_reset_in_load();
    clear_mem();
    imem[0] = 9'h1FF;
    do_reset();
    start_pulse();
    tick();
    #1 rst_n = 1'b0;
    tick();
    total++;
    if (instr !== 9'd0 || instr_valid !== 1'b0 || write !== 1'b0 || pc !== 8'd0) begin
      bad++;
      $display("FAIL load_reset: instr=%b valid=%b write=%b pc=%0d, want 0 0 0 0",
               instr, instr_valid, write, pc);
    end
    #1 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    total++;
    if (instr_valid !== 1'b0 || instr !== 9'd0 || pc !== 8'd0) begin
      bad++;
      $display("FAIL load_no_resume: valid=%b instr=%b pc=%0d, want 0 0 0", instr_valid, instr, pc);
    end
    push(8'd0, 9'h1FF, 1'b0);
    start_pulse();
    tick(); tick();
    total++;
    if (instr_valid !== 1'b1 || instr !== 9'h1FF || write !== 1'b0) begin
      bad++;
      $display("FAIL load_restart: valid=%b instr=%b write=%b, want 1 111111111 0", instr_valid, instr, write);
    end
    tick();
    total++;
    if (pc !== 8'd1 || sb.size() != 0) begin
      bad++; $display("FAIL load_restart_pc: pc=%0d pending=%0d, want 1 0", pc, sb.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = NOP_I;
    tick();
    test_reset();
    test_basic_decode();
    test_branch();
    test_stall_store();
    test_wrap();
    test_halt();
    test_reset_in_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
